// File: rtl/drive_pkg.sv
// drive_pkg: shared command/drive codes, FSM states and counter width for drive_sequencer
package drive_pkg;
  localparam int CNT_W = 8;
  localparam logic [2:0] CMD_STOP     = 3'd0;
  localparam logic [2:0] CMD_FWD_SLOW = 3'd1;
  localparam logic [2:0] CMD_FWD_FAST = 3'd2;
  localparam logic [2:0] CMD_REV      = 3'd3;
  localparam logic [2:0] CMD_PIVOT_L  = 3'd4;
  localparam logic [2:0] CMD_PIVOT_R  = 3'd5;
  localparam logic [1:0] DRV_OFF   = 2'd0;
  localparam logic [1:0] DRV_FWD50 = 2'd1;
  localparam logic [1:0] DRV_FWD75 = 2'd2;
  localparam logic [1:0] DRV_REV50 = 2'd3;
  typedef enum logic [1:0] {ST_STEADY, ST_DEAD, ST_RAMP, ST_FAULT} state_t;
  // Forward (either duty) to reverse or back needs a dead period first.
  function automatic logic is_rev(input logic [1:0] c, input logic [1:0] t);
    return ((c == DRV_FWD50 || c == DRV_FWD75) && t == DRV_REV50) ||
           (c == DRV_REV50 && (t == DRV_FWD50 || t == DRV_FWD75));
  endfunction
  // Code a motor takes on the accept edge: off if reversing, 50% if ramping to 75%.
  function automatic logic [1:0] accept_code(input logic [1:0] c, input logic [1:0] t);
    return is_rev(c, t) ? DRV_OFF : (t == DRV_FWD75 && c != DRV_FWD75) ? DRV_FWD50 : t;
  endfunction
endpackage

// File: rtl/period_timer.sv
// period_timer: counts PWM period ticks and flags the tick that reaches the limit
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : held during a state's entry cycle; zeroes the count and ignores that cycle's tick
//   i_tick         : one-cycle PWM period pulse
//   i_limit        : number of ticks to count (1..255)
//   o_done         : high on the cycle carrying the i_limit-th tick
module period_timer
  import drive_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_tick) r_cnt <= r_cnt + 1'b1;
  assign o_done = ~i_clear & i_tick & (r_cnt == i_limit - 1'b1);
endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: turns motion commands into DriveA/DriveB codes with soft-start ramp and reversal dead time
//   CLK, RSTn          : MCLK, async active-low reset
//   PeriodTick         : one pulse per PWM period
//   CmdValid/Cmd/CmdReady : command handshake, Cmd 0..5 legal, 6..7 act as STOP and pulse CmdErr
//   Stall              : forces both motors off and enters FAULT
//   DriveA, DriveB     : 0 off, 1 fwd 50%, 2 fwd 75%, 3 rev 50%
//   Busy               : complement of CmdReady
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int DEAD_PERIODS = 4,
  parameter int RAMP_PERIODS = 8
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       PeriodTick,
  input  logic       CmdValid,
  input  logic [2:0] Cmd,
  output logic       CmdReady,
  input  logic       Stall,
  output logic [1:0] DriveA,
  output logic [1:0] DriveB,
  output logic       Busy,
  output logic       CmdErr
);
  state_t           r_state;
  logic [1:0]       r_drive_a, r_drive_b, r_ta, r_tb;
  logic             r_rev_a, r_rev_b, r_err, r_entry;
  logic [1:0]       w_ta, w_tb, w_dead_a, w_dead_b;
  logic             w_accept, w_rev_a, w_rev_b, w_ramp, w_dead_ramp, w_done;
  logic [CNT_W-1:0] w_limit;
  assign CmdReady = (r_state == ST_STEADY) & ~Stall;
  assign Busy     = ~CmdReady;
  assign CmdErr   = r_err;
  assign DriveA   = r_drive_a;
  assign DriveB   = r_drive_b;
  assign w_accept = CmdValid & CmdReady;
  assign w_ta = (Cmd == CMD_REV || Cmd == CMD_PIVOT_L) ? DRV_REV50 :
                (Cmd == CMD_FWD_SLOW || Cmd == CMD_PIVOT_R) ? DRV_FWD50 :
                (Cmd == CMD_FWD_FAST) ? DRV_FWD75 : DRV_OFF;
  assign w_tb = (Cmd == CMD_REV || Cmd == CMD_PIVOT_R) ? DRV_REV50 :
                (Cmd == CMD_FWD_SLOW || Cmd == CMD_PIVOT_L) ? DRV_FWD50 :
                (Cmd == CMD_FWD_FAST) ? DRV_FWD75 : DRV_OFF;
  assign w_rev_a = is_rev(r_drive_a, w_ta);
  assign w_rev_b = is_rev(r_drive_b, w_tb);
  assign w_ramp  = (w_ta == DRV_FWD75 && r_drive_a != DRV_FWD75) ||
                   (w_tb == DRV_FWD75 && r_drive_b != DRV_FWD75);
  // At dead-period expiry a reversing motor heading for 75% enters at 50% and ramps.
  assign w_dead_a = r_rev_a ? ((r_ta == DRV_FWD75) ? DRV_FWD50 : r_ta) : r_drive_a;
  assign w_dead_b = r_rev_b ? ((r_tb == DRV_FWD75) ? DRV_FWD50 : r_tb) : r_drive_b;
  assign w_dead_ramp = (r_ta == DRV_FWD75 && w_dead_a != DRV_FWD75) ||
                       (r_tb == DRV_FWD75 && w_dead_b != DRV_FWD75);
  assign w_limit = (r_state == ST_DEAD) ? CNT_W'(DEAD_PERIODS) : CNT_W'(RAMP_PERIODS);
  period_timer u_timer (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_clear (r_entry),
    .i_tick  (PeriodTick),
    .i_limit (w_limit),
    .o_done  (w_done)
  );
  // r_entry marks the first cycle in a newly entered state so the timer restarts from zero.
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      r_state   <= ST_STEADY;
      r_drive_a <= DRV_OFF;
      r_drive_b <= DRV_OFF;
      r_ta      <= DRV_OFF;
      r_tb      <= DRV_OFF;
      r_rev_a   <= 1'b0;
      r_rev_b   <= 1'b0;
      r_err     <= 1'b0;
      r_entry   <= 1'b0;
    end else begin
      r_err   <= 1'b0;
      r_entry <= 1'b0;
      if (Stall) begin
        r_state   <= ST_FAULT;
        r_drive_a <= DRV_OFF;
        r_drive_b <= DRV_OFF;
        r_ta      <= DRV_OFF;
        r_tb      <= DRV_OFF;
        r_rev_a   <= 1'b0;
        r_rev_b   <= 1'b0;
        r_entry   <= r_state != ST_FAULT;
      end else begin
        unique case (r_state)
          ST_STEADY: if (w_accept) begin
            r_ta      <= w_ta;
            r_tb      <= w_tb;
            r_rev_a   <= w_rev_a;
            r_rev_b   <= w_rev_b;
            r_drive_a <= accept_code(r_drive_a, w_ta);
            r_drive_b <= accept_code(r_drive_b, w_tb);
            r_err     <= Cmd > CMD_PIVOT_R;
            r_state   <= (w_rev_a | w_rev_b) ? ST_DEAD : w_ramp ? ST_RAMP : ST_STEADY;
            r_entry   <= w_rev_a | w_rev_b | w_ramp;
          end
          ST_DEAD: if (w_done) begin
            r_drive_a <= w_dead_a;
            r_drive_b <= w_dead_b;
            r_state   <= w_dead_ramp ? ST_RAMP : ST_STEADY;
            r_entry   <= 1'b1;
          end
          ST_RAMP: if (w_done) begin
            r_drive_a <= r_ta;
            r_drive_b <= r_tb;
            r_state   <= ST_STEADY;
            r_entry   <= 1'b1;
          end
          ST_FAULT: begin
            r_state <= ST_DEAD;
            r_entry <= 1'b1;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: directed stimulus with a per-cycle behavioural model and literal checkpoints
module tb_drive_sequencer;
  localparam int DEAD = 4;
  localparam int RAMP = 8;
  logic       CLK = 0, RSTn = 0, PeriodTick = 0, CmdValid = 0, Stall = 0;
  logic [2:0] Cmd = 0;
  logic       CmdReady, Busy, CmdErr;
  logic [1:0] DriveA, DriveB;
  int n_checks = 0, n_errors = 0;

  drive_sequencer #(.DEAD_PERIODS(DEAD), .RAMP_PERIODS(RAMP)) dut (
    .CLK(CLK), .RSTn(RSTn), .PeriodTick(PeriodTick), .CmdValid(CmdValid), .Cmd(Cmd),
    .CmdReady(CmdReady), .Stall(Stall), .DriveA(DriveA), .DriveB(DriveB),
    .Busy(Busy), .CmdErr(CmdErr)
  );

  initial forever #5 CLK = ~CLK;

  initial forever begin
    repeat (127) @(negedge CLK);
    PeriodTick = 1;
    @(negedge CLK);
    PeriodTick = 0;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: motor codes, targets and countdowns of remaining PWM ticks per phase.
  int m_a, m_b, m_ta, m_tb, dead_left, ramp_left;
  bit m_ra, m_rb, fault, fresh, m_err;

  function automatic int tgt_a(input int c);
    case (c) 1: return 1; 2: return 2; 3: return 3; 4: return 3; 5: return 1; default: return 0; endcase
  endfunction
  function automatic int tgt_b(input int c);
    case (c) 1: return 1; 2: return 2; 3: return 3; 4: return 1; 5: return 3; default: return 0; endcase
  endfunction
  function automatic bit reverses(input int c, input int t);
    return ((c == 1 || c == 2) && t == 3) || (c == 3 && (t == 1 || t == 2));
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_ta = 0; m_tb = 0; dead_left = 0; ramp_left = 0;
    m_ra = 0; m_rb = 0; fault = 0; fresh = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit st, input bit tk);
    m_err = 0;
    if (st) begin
      m_a = 0; m_b = 0; m_ta = 0; m_tb = 0; fault = 1; dead_left = 0; ramp_left = 0;
    end else if (fault) begin
      fault = 0; m_ra = 0; m_rb = 0; dead_left = DEAD; fresh = 1;
    end else if (dead_left > 0) begin
      if (fresh) fresh = 0;
      else if (tk) begin
        dead_left--;
        if (dead_left == 0) begin
          if (m_ra) m_a = (m_ta == 2) ? 1 : m_ta;
          if (m_rb) m_b = (m_tb == 2) ? 1 : m_tb;
          if ((m_ta == 2 && m_a != 2) || (m_tb == 2 && m_b != 2)) begin ramp_left = RAMP; fresh = 1; end
        end
      end
    end else if (ramp_left > 0) begin
      if (fresh) fresh = 0;
      else if (tk) begin
        ramp_left--;
        if (ramp_left == 0) begin m_a = m_ta; m_b = m_tb; end
      end
    end else if (v) begin
      m_ta = tgt_a(c); m_tb = tgt_b(c); m_err = c > 5;
      m_ra = reverses(m_a, m_ta); m_rb = reverses(m_b, m_tb);
      m_a = m_ra ? 0 : (m_ta == 2 && m_a != 2) ? 1 : m_ta;
      m_b = m_rb ? 0 : (m_tb == 2 && m_b != 2) ? 1 : m_tb;
      if (m_ra || m_rb) begin dead_left = DEAD; fresh = 1; end
      else if ((m_ta == 2 && m_a != 2) || (m_tb == 2 && m_b != 2)) begin ramp_left = RAMP; fresh = 1; end
    end
  endtask

  initial begin : model_compare
    bit idle;
    model_reset();
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) model_reset();
      else begin
        model_step(CmdValid, int'(Cmd), Stall, PeriodTick);
        #1;
        if (RSTn) begin
          idle = !fault && dead_left == 0 && ramp_left == 0;
          chk("model DriveA", DriveA, m_a);
          chk("model DriveB", DriveB, m_b);
          chk("model CmdReady", CmdReady, idle && !Stall);
          chk("model Busy", Busy, !(idle && !Stall));
          chk("model CmdErr", CmdErr, m_err);
        end
      end
    end
  end

  task automatic send(input logic [2:0] c);
    @(negedge CLK);
    Cmd = c;
    CmdValid = 1;
    @(posedge CLK);
    #1;
    CmdValid = 0;
  endtask

  task automatic expect_out(input string name, input int a, input int b, input int rdy);
    chk({name, " DriveA"}, DriveA, a);
    chk({name, " DriveB"}, DriveB, b);
    chk({name, " CmdReady"}, CmdReady, rdy);
    chk({name, " Busy"}, Busy, !rdy);
  endtask

  // Waits for CmdReady, counting ticks after the first `skip` edges (entry cycles ignore ticks).
  task automatic wait_ready(input int skip, input int t0, input int exp_ticks, input string name);
    int t = t0;
    bit ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(posedge CLK);
      if (n >= skip && PeriodTick) t++;
      #1;
      ok = CmdReady;
    end
    chk({name, " ready within budget"}, ok, 1);
    chk({name, " tick latency"}, t, exp_ticks);
  endtask

  initial begin : stim
    int t;
    repeat (3) @(posedge CLK);
    #1 expect_out("reset", 0, 0, 1);
    chk("reset CmdErr", CmdErr, 0);
    @(negedge CLK) RSTn = 1;
    send(3'd1); expect_out("fwd_slow", 1, 1, 1);
    send(3'd0); expect_out("stop", 0, 0, 1);
    send(3'd2); expect_out("fwd_fast start", 1, 1, 0);
    wait_ready(1, 0, 8, "ramp");
    expect_out("fwd_fast end", 2, 2, 1);
    send(3'd3); expect_out("rev start", 0, 0, 0);
    @(negedge CLK);
    Cmd = 3'd0;
    CmdValid = 1;
    t = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      if (i > 0 && PeriodTick) t++;
      #1 expect_out("cmd during dead", 0, 0, 0);
    end
    @(negedge CLK) CmdValid = 0;
    wait_ready(0, t, 4, "rev");
    expect_out("rev end", 3, 3, 1);
    send(3'd2); expect_out("rev to fast start", 0, 0, 0);
    wait_ready(1, 0, 12, "rev to fast");
    expect_out("rev to fast end", 2, 2, 1);
    send(3'd0); expect_out("stop2", 0, 0, 1);
    send(3'd1); expect_out("fwd_slow2", 1, 1, 1);
    send(3'd4); expect_out("pivot_l start", 0, 1, 0);
    wait_ready(1, 0, 4, "pivot_l");
    expect_out("pivot_l end", 3, 1, 1);
    @(negedge CLK);
    Stall = 1;
    Cmd = 3'd1;
    CmdValid = 1;
    @(posedge CLK);
    #1 expect_out("stall beats accept", 0, 0, 0);
    CmdValid = 0;
    repeat (3) @(negedge CLK);
    Stall = 0;
    wait_ready(2, 0, 4, "fault recovery");
    expect_out("fault recovered", 0, 0, 1);
    send(3'd2); expect_out("ramp before stall", 1, 1, 0);
    repeat (50) @(posedge CLK);
    @(negedge CLK) Stall = 1;
    @(posedge CLK);
    #1 expect_out("stall in ramp", 0, 0, 0);
    @(negedge CLK) Stall = 0;
    wait_ready(2, 0, 4, "ramp stall recovery");
    expect_out("ramp stall recovered", 0, 0, 1);
    send(3'd3); expect_out("rev from idle", 3, 3, 1);
    send(3'd7); expect_out("illegal cmd", 0, 0, 1);
    chk("illegal CmdErr pulse", CmdErr, 1);
    @(posedge CLK);
    #1 chk("CmdErr one cycle", CmdErr, 0);
    send(3'd1); expect_out("pre reset fwd", 1, 1, 1);
    send(3'd3); expect_out("pre reset dead", 0, 0, 0);
    repeat (20) @(posedge CLK);
    #3 RSTn = 0;
    #1 expect_out("async reset in dead", 0, 0, 1);
    chk("async reset CmdErr", CmdErr, 0);
    @(negedge CLK) RSTn = 1;
    send(3'd2); expect_out("pre reset ramp", 1, 1, 0);
    repeat (20) @(posedge CLK);
    #3 RSTn = 0;
    #1 expect_out("async reset in ramp", 0, 0, 1);
    @(negedge CLK) RSTn = 1;
    send(3'd5); expect_out("pivot_r after reset", 1, 3, 1);
    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
